character_display_scanner: RTL and testbench

- Time-multiplexes four 4-bit character codes onto one shared character_to_segment instance and drives the four active-low digit anodes.
- Sits directly upstream of character_to_segment: char_code feeds its binary_in, and its seven_out goes to the segment pins.
- Game/control logic loads new 4-character frames through a valid/ready handshake. Updates are applied only at frame boundaries, so no digit ever shows a torn frame.
- Supports per-digit blinking.

---
 rtl/character_display_scanner.sv | 161 ++++++++++++++++
 tb/tb_character_display_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/character_display_scanner.sv
// Purpose : time-multiplexes four 4-bit character codes onto one shared
//           character_to_segment decoder and drives active-low digit anodes.
// Latency : outputs are registered and track the scan state of the same
//           cycle. A new frame becomes visible on the digit-0 slot right
//           after the frame boundary.
// Backpressure: load_ready drops while a frame waits for the next boundary.
//           A request offered while load_ready=0 is ignored and must be held.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load_valid/ready  frame handshake; load_ready comes only from state
//   load_chars[15:0]  digit i code in bits [4i+3:4i]
//   load_blink[3:0]   per-digit blink enable
//   char_code[3:0]    sanitised code of the lit digit (to binary_in)
//   anode_n[3:0]      active-low one-hot digit enable
//   frame_tick        one-cycle pulse in the last cycle of each scan frame
module character_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_chars,
  input  logic [3:0]  load_blink,
  output logic [3:0]  char_code,
  output logic [3:0]  anode_n,
  output logic        frame_tick
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    BLANK    = 4'd11;

  // Scan and blink state
  logic [RW-1:0] refresh_cnt, refresh_nxt;
  logic [1:0]    digit_idx, digit_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;

  // Frame currently displayed, and one-deep holding buffer
  logic [15:0]   active_chars, active_chars_nxt;
  logic [3:0]    active_blink, active_blink_nxt;
  logic [15:0]   pend_chars, pend_chars_nxt;
  logic [3:0]    pend_blink, pend_blink_nxt;
  logic          pend_vld, pend_vld_nxt;

  // Registered output next values
  logic [3:0]    char_nxt, anode_nxt;
  logic          tick_nxt;

  logic          slot_end, boundary, xfer;
  logic [3:0]    raw_code;

  // Decoder only knows codes 0..11; anything above shows as blank.
  function automatic logic [3:0] sanitize(input logic [3:0] c);
    return (c > 4'd11) ? BLANK : c;
  endfunction

  assign load_ready = ~pend_vld;
  assign slot_end   = (refresh_cnt == REF_LAST);
  assign boundary   = slot_end && (digit_idx == 2'd3);
  assign xfer       = load_valid && load_ready;

  always_comb begin
    refresh_nxt      = refresh_cnt;
    digit_nxt        = digit_idx;
    blink_cnt_nxt    = blink_cnt;
    blink_phase_nxt  = blink_phase;
    active_chars_nxt = active_chars;
    active_blink_nxt = active_blink;
    pend_chars_nxt   = pend_chars;
    pend_blink_nxt   = pend_blink;
    pend_vld_nxt     = pend_vld;
    raw_code         = BLANK;
    char_nxt         = BLANK;
    anode_nxt        = 4'b1111;
    tick_nxt         = 1'b0;

    if (slot_end) begin
      refresh_nxt = '0;
      digit_nxt   = digit_idx + 2'd1;
    end else begin
      refresh_nxt = refresh_cnt + 1'b1;
    end

    if (boundary) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end

    // A transfer landing on the boundary bypasses the holding buffer.
    // xfer and pend_vld are mutually exclusive, so only one branch fires.
    if (boundary && xfer) begin
      active_chars_nxt = load_chars;
      active_blink_nxt = load_blink;
    end else if (boundary && pend_vld) begin
      active_chars_nxt = pend_chars;
      active_blink_nxt = pend_blink;
      pend_vld_nxt     = 1'b0;
    end else if (xfer) begin
      pend_chars_nxt = load_chars;
      pend_blink_nxt = load_blink;
      pend_vld_nxt   = 1'b1;
    end

    // Outputs are computed from next state so they line up with the scan
    // state held in the same cycle.
    case (digit_nxt)
      2'd0:    raw_code = active_chars_nxt[3:0];
      2'd1:    raw_code = active_chars_nxt[7:4];
      2'd2:    raw_code = active_chars_nxt[11:8];
      default: raw_code = active_chars_nxt[15:12];
    endcase
    char_nxt = sanitize(raw_code);

    if (blink_phase_nxt && active_blink_nxt[digit_nxt])
      anode_nxt = 4'b1111;
    else
      anode_nxt = ~(4'b0001 << digit_nxt);

    tick_nxt = (refresh_nxt == REF_LAST) && (digit_nxt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt  <= '0;
      digit_idx    <= 2'd0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      active_chars <= {4{BLANK}};
      active_blink <= 4'b0000;
      pend_chars   <= '0;
      pend_blink   <= 4'b0000;
      pend_vld     <= 1'b0;
      char_code    <= BLANK;
      anode_n      <= 4'b1111;
      frame_tick   <= 1'b0;
    end else begin
      refresh_cnt  <= refresh_nxt;
      digit_idx    <= digit_nxt;
      blink_cnt    <= blink_cnt_nxt;
      blink_phase  <= blink_phase_nxt;
      active_chars <= active_chars_nxt;
      active_blink <= active_blink_nxt;
      pend_chars   <= pend_chars_nxt;
      pend_blink   <= pend_blink_nxt;
      pend_vld     <= pend_vld_nxt;
      char_code    <= char_nxt;
      anode_n      <= anode_nxt;
      frame_tick   <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_character_display_scanner.sv
// Purpose : self-checking bench for character_display_scanner with
//           REFRESH_DIV=4, BLINK_DIV=2 (16-cycle frames, 2-frame blink half-period).
// Ports   : drives every DUT port; expected values go into a queue from the
//           stimulus process and a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_character_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_chars = '0;
  logic [3:0]  load_blink = '0;
  logic [3:0]  char_code;
  logic [3:0]  anode_n;
  logic        frame_tick;

  character_display_scanner #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_chars(load_chars), .load_blink(load_blink), .char_code(char_code),
    .anode_n(anode_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] code;
    logic       tick;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   t      = 0;     // cycles since the last reset edge
  logic [15:0] exp_chars = 16'hBBBB;  // frame expected on the display (hand-sanitised)
  logic [3:0]  exp_mask  = 4'b0000;
  bit          done = 1'b0;

  // Expected display for cycle tt: 4 cycles per slot, 16 per frame, blink
  // phase visible for frames 0,1, blanked for 2,3, and so on.
  function automatic exp_t mk(input int tt, input logic rdy);
    exp_t e;
    int d, ph;
    d  = (tt / 4) % 4;
    ph = ((tt / 16) / 2) % 2;
    e.t    = tt;
    e.rdy  = rdy;
    e.tick = (tt % 16 == 15);
    e.code = exp_chars[d*4 +: 4];
    if (ph == 1 && exp_mask[d]) e.an = 4'b1111;
    else                        e.an = ~(4'b0001 << d);
    if (tt == 0) begin
      e.an   = 4'b1111;
      e.code = 4'd11;
    end
    return e;
  endfunction

  // One cycle: drive inputs, queue the expectation for this cycle.
  task automatic step(input logic r, input logic lv, input logic [15:0] lc,
                      input logic [3:0] lb, input logic er);
    @(negedge clk);
    rst        = r;
    load_valid = lv;
    load_chars = lc;
    load_blink = lb;
    q.push_back(mk(t, er));
    if (r) t = 0;
    else   t = t + 1;
  endtask

  task automatic idle(input int n, input logic er);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 4'h0, er);
  endtask

  task automatic chk(input int tt, input string nm, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s t=%0d got=%b want=%b", nm, tt, got, want);
  endtask

  // Monitor: compares after the stimulus has pushed for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.t, "anode_n",    anode_n,           e.an);
        chk(e.t, "char_code",  char_code,         e.code);
        chk(e.t, "frame_tick", {3'b0, frame_tick}, {3'b0, e.tick});
        chk(e.t, "load_ready", {3'b0, load_ready}, {3'b0, e.rdy});
      end
      if (done) break;
    end
  end

  initial begin
    @(posedge clk);
    // Reset state, checked while reset is still held
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b1);

    // 1: load 3210 in the first post-reset cycle; visible from t=16
    step(1'b0, 1'b1, 16'h3210, 4'h0, 1'b1);
    idle(15, 1'b0);
    exp_chars = 16'h3210;
    idle(32, 1'b1);                                   // t=16..47

    // 2: FC95 -> C and F sanitised to 11
    step(1'b0, 1'b1, 16'hFC95, 4'h0, 1'b1);           // t=48
    idle(15, 1'b0);
    exp_chars = 16'hBB95;
    idle(16, 1'b1);                                   // t=64..79

    // 3: mid-frame load, second request held while not ready
    idle(6, 1'b1);                                    // t=80..85
    step(1'b0, 1'b1, 16'h1111, 4'h0, 1'b1);           // t=86
    idle(1, 1'b0);                                    // t=87
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);         // t=88..95 ignored
    exp_chars = 16'h1111;
    step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b1);           // t=96 accepted
    idle(15, 1'b0);
    exp_chars = 16'h2222;
    idle(16, 1'b1);                                   // t=112..127

    // 4: transfer exactly in the frame_tick cycle
    idle(15, 1'b1);                                   // t=128..142
    step(1'b0, 1'b1, 16'h4444, 4'h0, 1'b1);           // t=143
    exp_chars = 16'h4444;
    idle(16, 1'b1);                                   // t=144..159

    // 5: blink digits 0 and 2
    step(1'b0, 1'b1, 16'h3210, 4'b0101, 1'b1);        // t=160
    idle(15, 1'b0);
    exp_chars = 16'h3210;
    exp_mask  = 4'b0101;
    idle(80, 1'b1);                                   // t=176..255

    // 6: reset while a frame is pending
    step(1'b0, 1'b1, 16'h5555, 4'h0, 1'b1);           // t=256
    idle(1, 1'b0);                                    // t=257
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);           // t=258, reset edge follows
    exp_chars = 16'hBBBB;
    exp_mask  = 4'b0000;
    idle(40, 1'b1);                                   // blank across a boundary

    done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain left=%0d want=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
